// File: rtl/alu_muldiv.sv
// Handshaked ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring unsigned divide (one bit per cycle).
//
// state | meaning
// IDLE  | ready to accept an operation
// BUSY  | iterating MUL/DIVU/REMU, WIDTH cycles
// DONE  | result presented, waiting for out_ready
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] ALUop2,
  input  logic [3:0]       ALUctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUout,
  output logic             Zero,
  output logic             EQ
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_ctrl;
  logic              r_eq_cap;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_sh;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_out;
  logic              r_zero;
  logic              r_eq;

  logic              w_accept;
  logic              w_multi;
  logic              w_last;
  logic [SH_W-1:0]   w_shamt;
  logic [WIDTH-1:0]  w_alu;
  logic [WIDTH:0]    w_shifted;
  logic              w_ge;
  logic [WIDTH-1:0]  w_acc_nxt;
  logic [WIDTH-1:0]  w_sh_nxt;
  logic [WIDTH-1:0]  w_b_nxt;
  logic [WIDTH-1:0]  w_mres;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_multi  = (ALUctrl == OP_MUL) || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shamt  = ALUop2[SH_W-1:0];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_comb begin
    w_alu = '0;
    case (ALUctrl)
      OP_ADD:  w_alu = ALUop1 + ALUop2;
      OP_SUB:  w_alu = ALUop1 - ALUop2;
      OP_AND:  w_alu = ALUop1 & ALUop2;
      OP_OR:   w_alu = ALUop1 | ALUop2;
      OP_XOR:  w_alu = ALUop1 ^ ALUop2;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      OP_SLL:  w_alu = ALUop1 << w_shamt;
      OP_SRL:  w_alu = ALUop1 >> w_shamt;
      OP_SRA:  w_alu = $signed(ALUop1) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // r_acc: product accumulator or partial remainder; r_sh: multiplier or
  // dividend shifting out while quotient bits shift in; r_b: multiplicand or divisor.
  assign w_shifted = {r_acc, r_sh[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, r_b});

  always_comb begin
    w_acc_nxt = r_acc;
    w_sh_nxt  = r_sh;
    w_b_nxt   = r_b;
    if (r_ctrl == OP_MUL) begin
      w_acc_nxt = r_sh[0] ? (r_acc + r_b) : r_acc;
      w_sh_nxt  = r_sh >> 1;
      w_b_nxt   = r_b << 1;
    end else begin
      w_acc_nxt = w_ge ? (w_shifted[WIDTH-1:0] - r_b) : w_shifted[WIDTH-1:0];
      w_sh_nxt  = {r_sh[WIDTH-2:0], w_ge};
    end
  end

  assign w_mres = (r_ctrl == OP_DIVU) ? w_sh_nxt : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_eq_cap <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_b      <= '0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_eq     <= 1'b0;
    end else if (w_accept) begin
      r_ctrl   <= ALUctrl;
      r_eq_cap <= (ALUop1 == ALUop2);
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sh     <= (ALUctrl == OP_MUL) ? ALUop2 : ALUop1;
      r_b      <= (ALUctrl == OP_MUL) ? ALUop1 : ALUop2;
      if (!w_multi) begin
        r_out  <= w_alu;
        r_zero <= (w_alu == '0);
        r_eq   <= (ALUop1 == ALUop2);
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nxt;
      r_sh  <= w_sh_nxt;
      r_b   <= w_b_nxt;
      if (w_last) begin
        r_out  <= w_mres;
        r_zero <= (w_mres == '0);
        r_eq   <= r_eq_cap;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ALUout = r_out;
  assign Zero   = r_zero;
  assign EQ     = r_eq;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: operand and result width in bits, at least 8.
REQ-002 The block SHALL take parameter CNT_W, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have ports ALUop1 and ALUop2, inputs, WIDTH bits each: operands.
REQ-008 The block SHALL have port ALUctrl, input, 4 bits: operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port ALUout, output, WIDTH bits: registered result.
REQ-012 The block SHALL have port Zero, output, 1 bit: registered, (ALUout == 0).
REQ-013 The block SHALL have port EQ, output, 1 bit: registered, (ALUop1 == ALUop2) captured at accept.

Function
REQ-014 An operation SHALL be accepted on a rising edge where in_valid && in_ready; operands and ALUctrl SHALL be captured at that edge.
REQ-015 The state machine SHALL have three states:
- IDLE: in_ready=1.
- BUSY: in_ready=0.
- DONE: in_ready=0, out_valid=1.
REQ-016 Single-cycle ops SHALL go IDLE->DONE on accept, so out_valid is high on the cycle after accept:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR
- 0101 SLT (signed, result 1/0); 0110 SLTU (unsigned)
- 0111 SLL; 1000 SRL; 1001 SRA
- Shift amount = ALUop2[$clog2(WIDTH)-1:0].
REQ-017 Multi-cycle ops SHALL go IDLE->BUSY on accept:
- 1010 MUL: low WIDTH bits of the product, shift-add, one bit per cycle.
- 1011 DIVU: quotient, restoring, one bit per cycle.
- 1100 REMU: remainder, restoring, one bit per cycle.
REQ-018 A multi-cycle op SHALL stay in BUSY exactly WIDTH cycles, then enter DONE, so out_valid rises WIDTH+1 cycles after accept.
REQ-019 Undefined ALUctrl codes (1101-1111) SHALL complete as single-cycle ops with ALUout=0 and Zero=1.
REQ-020 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-021 DIVU/REMU with divisor 0 SHALL complete in the normal WIDTH+1 cycles: DIVU gives all ones, REMU gives ALUop1.
REQ-022 DONE->IDLE SHALL occur on the edge where out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, ALUout, Zero and EQ SHALL hold stable.
REQ-024 If out_ready is already high when DONE is entered, out_valid SHALL be high for exactly one cycle; in_ready SHALL return to 1 on the next cycle, with no same-cycle accept.
REQ-025 in_valid SHALL be ignored in BUSY and DONE; a new op SHALL NOT be captured and captured operands SHALL NOT change.
REQ-026 ALUout, Zero and EQ SHALL update only on entry to DONE.
REQ-027 The iteration counter SHALL be CNT_W bits, SHALL count 0..WIDTH-1, and SHALL clear on accept.

Reset
REQ-028 When rst_n=0, regardless of clk, the block SHALL:
- enter IDLE;
- set in_ready=1, out_valid=0;
- clear ALUout, Zero, EQ, the counter and all datapath registers to 0.
REQ-029 Reset asserted during BUSY or DONE SHALL abort the operation with no result delivered; the first accept after reset release SHALL behave as from power-up.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 at the first rising edge.

Verification
REQ-031 With WIDTH=32, ADD 0xFFFFFFFF+0x00000001 with out_ready=1 -> out_valid one cycle after accept, ALUout=0, Zero=1, EQ=0.
REQ-032 With WIDTH=32, SLT 0xFFFFFFFF vs 0x00000001 -> ALUout=1; SLTU on the same operands -> ALUout=0, Zero=1.
REQ-033 With WIDTH=32, MUL 0x00010003*0x00020005 -> in_ready low for 33 cycles, out_valid at accept+33, ALUout=0x000B000F.
REQ-034 With WIDTH=32, DIVU 100/7 -> ALUout=14 at accept+33; REMU 100/7 -> ALUout=2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-035 With WIDTH=32, hold out_ready=0 for 10 cycles after DONE while toggling in_valid and operands -> ALUout stable, no new accept, in_ready=0; raise out_ready -> IDLE on the next edge.
REQ-036 With WIDTH=32, assert rst_n=0 mid-BUSY at cycle 10 of a MUL -> out_valid=0, ALUout=0, in_ready=1 immediately; a following SRA 0x80000000>>4 -> 0xF8000000.
